// File: rtl/icache_pkg.sv
// Shared types and width helpers for the 2-way set-associative instruction cache.
package icache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  // Word-offset bits within a line.
  function automatic int off_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  // Set-index bits.
  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Tag bits: whatever remains of the word address above offset and index.
  function automatic int tag_bits(input int addr_w, input int sets, input int line_words);
    return addr_w - $clog2(sets) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the cache: per-set valid bit, tag and line, with a combinational
// read port and a single-line fill port.
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS   = 8,
  parameter int TAG_W  = 25,
  parameter int LINE_W = 128
) (
  input  logic                      clk,
  input  logic                      proc_reset,
  input  logic [idx_bits(SETS)-1:0] rd_index,
  output logic                      rd_valid,
  output logic [TAG_W-1:0]          rd_tag,
  output logic [LINE_W-1:0]         rd_line,
  input  logic                      fill_en,
  input  logic [idx_bits(SETS)-1:0] fill_index,
  input  logic [TAG_W-1:0]          fill_tag,
  input  logic [LINE_W-1:0]         fill_line
);

  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

  // Next valid vector: a fill marks its set valid.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (which would infer a latch).
    valid_d = valid_q;
    if (fill_en) valid_d[fill_index] = 1'b1;
  end

  // Valid register; reset invalidates every set.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (proc_reset) valid_q <= '0;
    else            valid_q <= valid_d;
  end

  // Tag and line storage, written only on a fill.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately not reset; the valid bits alone decide whether an entry is meaningful.
    if (fill_en) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= fill_line;
    end
  end

endmodule

// File: rtl/i_l1cache_assoc.sv
// 2-way set-associative, read-only L1 instruction cache with LRU replacement
// and a blocking IDLE/REFILL miss FSM.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module i_l1cache_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                                   clk,
  input  logic                                   proc_reset,
  input  logic                                   proc_read,
  input  logic                                   proc_write,
  input  logic [ADDR_W-1:0]                      proc_addr,
  input  logic [WORD_W-1:0]                      proc_wdata,
  output logic                                   proc_stall,
  output logic [WORD_W-1:0]                      proc_rdata,
  output logic                                   mem_read,
  output logic                                   mem_write,
  output logic [ADDR_W-off_bits(LINE_WORDS)-1:0] mem_addr,
  output logic [WORD_W*LINE_WORDS-1:0]           mem_wdata,
  input  logic [WORD_W*LINE_WORDS-1:0]           mem_rdata,
  input  logic                                   mem_ready,
  output logic [31:0]                            hit_cnt,
  output logic [31:0]                            miss_cnt
);

  localparam int OFF_W  = off_bits(LINE_WORDS);
  localparam int IDX_W  = idx_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_W, SETS, LINE_WORDS);
  localparam int LINE_W = WORD_W * LINE_WORDS;

  // Address fields, LSB first: offset, index, tag.
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;

  assign req_off = proc_addr[OFF_W-1:0];
  assign req_idx = proc_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag = proc_addr[ADDR_W-1:OFF_W+IDX_W];

  state_e           state_q, state_d;
  logic [SETS-1:0]  lru_q, lru_d;     // per set: the way to replace next
  logic [1:0]       way_valid;
  logic [TAG_W-1:0] way_tag  [2];
  logic [LINE_W-1:0] way_line [2];
  logic [1:0]       way_hit;
  logic [1:0]       way_fill;
  logic             hit;
  logic             hit_way;
  logic             victim;
  logic             miss_start;

  icache_way #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way0 (
    .clk        (clk),
    .proc_reset (proc_reset),
    .rd_index   (req_idx),
    .rd_valid   (way_valid[0]),
    .rd_tag     (way_tag[0]),
    .rd_line    (way_line[0]),
    .fill_en    (way_fill[0]),
    .fill_index (req_idx),
    .fill_tag   (req_tag),
    .fill_line  (mem_rdata)
  );

  icache_way #(.SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way1 (
    .clk        (clk),
    .proc_reset (proc_reset),
    .rd_index   (req_idx),
    .rd_valid   (way_valid[1]),
    .rd_tag     (way_tag[1]),
    .rd_line    (way_line[1]),
    .fill_en    (way_fill[1]),
    .fill_index (req_idx),
    .fill_tag   (req_tag),
    .fill_line  (mem_rdata)
  );

  // Tag compare per way; a line lives in at most one way, so way 1 hitting picks way 1.
  assign way_hit[0] = way_valid[0] && (way_tag[0] == req_tag);
  assign way_hit[1] = way_valid[1] && (way_tag[1] == req_tag);
  assign hit        = proc_read && (state_q == IDLE) && (way_hit != 2'b00);
  assign hit_way    = way_hit[1];

  // Victim: first invalid way (way 0 first), otherwise the set's LRU way.
  assign victim = !way_valid[0] ? 1'b0 :
                  !way_valid[1] ? 1'b1 : lru_q[req_idx];

  // Miss FSM next state, LRU update, fill strobes and processor/memory outputs.
  always_comb begin
    state_d    = state_q;
    lru_d      = lru_q;
    way_fill   = 2'b00;
    miss_start = 1'b0;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    proc_rdata = way_line[hit_way][WORD_W*req_off +: WORD_W];
    case (state_q)
      IDLE: begin
        if (proc_read) begin
          if (hit) begin
            lru_d[req_idx] = ~hit_way;
          end else begin
            proc_stall = 1'b1;
            miss_start = 1'b1;
            state_d    = REFILL;
          end
        end
      end
      REFILL: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        if (mem_ready) begin
          state_d = IDLE;
          // A reset on the same edge aborts the refill without writing the line.
          if (!proc_reset) begin
            way_fill[victim] = 1'b1;
            lru_d[req_idx]   = ~victim;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and LRU bits.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= IDLE;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      lru_q   <= lru_d;
    end
  end

  assign mem_addr  = proc_addr[ADDR_W-1:OFF_W];
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

  // Writes are not supported; the write strobe and data are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{proc_write, proc_wdata};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        refill_done_q, refill_done_d;

  // Saturating counters; the word served right after a refill completes a
  // miss, so it is not counted again as a hit.
  always_comb begin
    refill_done_d = (state_q == REFILL) && mem_ready;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    if (hit && !refill_done_q && (hit_cnt_q != 32'hFFFF_FFFF))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      refill_done_q <= 1'b0;
    end else begin
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      refill_done_q <= refill_done_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: doc/i_l1cache_assoc.md
I_L1CACHE_ASSOC -- requirements
Module: i_l1cache_assoc

Interface
REQ-001 SHALL have parameter ADDR_W, default 30: processor word-address width.
REQ-002 SHALL have parameter SETS, default 8: sets, power of two and at least 2.
REQ-003 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line, power of two and at least 2.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port proc_reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port proc_read, input, 1: fetch request.
REQ-007 SHALL have port proc_write, input, 1: write request, ignored (read-only cache).
REQ-008 SHALL have port proc_addr, input, ADDR_W: word address.
REQ-009 SHALL have port proc_wdata, input, 32: unused.
REQ-010 SHALL have port proc_stall, output, 1: request not yet served.
REQ-011 SHALL have port proc_rdata, output, 32: fetched word.
REQ-012 SHALL have port mem_read, output, 1: line refill request.
REQ-013 SHALL have port mem_write, output, 1: constant 0.
REQ-014 SHALL have port mem_addr, output, ADDR_W-log2(LINE_WORDS): line address.
REQ-015 SHALL have port mem_wdata, output, 32*LINE_WORDS: constant 0.
REQ-016 SHALL have port mem_rdata, input, 32*LINE_WORDS: refill line, word 0 in the LSBs.
REQ-017 SHALL have port mem_ready, input, 1: mem_rdata valid this cycle.
REQ-018 SHALL have port hit_cnt, output, 32: hit count.
REQ-019 SHALL have port miss_cnt, output, 32: miss count.

Function
REQ-020 SHALL split proc_addr LSB-first into offset (log2 LINE_WORDS bits), index (log2 SETS bits) and tag (remaining bits).
REQ-021 SHALL be 2-way set-associative: per set and way one valid bit, one tag and one line, plus one LRU bit per set.
REQ-022 SHALL detect a hit combinationally when proc_read=1, state=IDLE and either way of the indexed set is valid with a matching tag.
REQ-023 SHALL on a hit drive proc_stall=0 and proc_rdata=the offset word of the hit way in the same cycle, and set that set's LRU bit to the other way at the clock edge.
REQ-024 SHALL use a two-state FSM, IDLE and REFILL: IDLE goes to REFILL on proc_read with a miss; REFILL goes to IDLE on the edge where mem_ready=1; every other case holds the state.
REQ-025 SHALL hold proc_stall=1 on a miss in IDLE and throughout REFILL.
REQ-026 SHALL drive mem_read=1 exactly while in REFILL, with mem_addr={tag,index} of proc_addr held stable; proc_addr is stable while stalled.
REQ-027 SHALL on the mem_ready edge write mem_rdata, the tag and valid=1 into the victim way (first invalid way, way 0 if both invalid, otherwise the LRU way) and set LRU to the other way.
REQ-028 SHALL serve the refilled word as a hit in the cycle after the REFILL exit: miss latency = memory wait + 1 cycle.
REQ-029 SHALL ignore mem_ready outside REFILL.
REQ-030 SHALL treat proc_write alone as a no-op with proc_stall=0; proc_read together with proc_write SHALL be treated as a read.
REQ-031 SHALL drive proc_stall=0 when idle with no request; proc_rdata is don't-care except on a hit.

Reset
REQ-032 SHALL on a proc_reset edge set state=IDLE, clear all valid and LRU bits and clear both counters; tags and data are not reset.
REQ-033 SHALL abort any refill in progress when reset occurs, so mem_read=0 from the cycle after the reset edge; no line is written.

Configuration
REQ-034 SHALL with ICACHE_STATS_EN defined increment hit_cnt once per served hit and miss_cnt once per IDLE-to-REFILL transition, both saturating at 0xFFFFFFFF.
REQ-035 SHALL without ICACHE_STATS_EN tie hit_cnt and miss_cnt to 0 and implement no counter registers.

Structure
REQ-036 SHALL place the FSM state enum and the offset/index/tag width helper constants in the shared package icache_pkg.
REQ-037 SHALL implement one sub-module, icache_way, instantiated twice: one way's valid, tag and data arrays with read port and fill port.

Verification
REQ-038 SHALL cover this scenario: after reset, read 0x10 -> stall=1, mem_read=1, mem_addr=0x4; mem_ready with line W3..W0 -> next cycle stall=0, rdata=W0.
REQ-039 SHALL cover this scenario: fill 0x00, then 0x20 (same set 0, tags 0 and 1) -> a re-read of 0x00 and of 0x20 each hits with mem_read=0.
REQ-040 SHALL cover this scenario: after REQ-039, read 0x00 then miss on 0x40 -> 0x20 is evicted; re-reading 0x20 misses and re-reading 0x00 hits.
REQ-041 SHALL cover this scenario: mem_ready delayed 5 cycles -> mem_read, mem_addr and stall are held constant for all 5 cycles.
REQ-042 SHALL cover this scenario: reset pulsed mid-REFILL -> mem_read=0 the next cycle and a re-read of a previously filled address misses.
REQ-043 SHALL cover this scenario: with ICACHE_STATS_EN, 3 misses and 2 hits -> miss_cnt=3, hit_cnt=2; without the macro -> both counters read 0.
